// File: rtl/router_pkg.sv
// router_pkg: shared widths, state encoding and header field helpers for the router ingress.
package router_pkg;
    localparam int LEN_W  = 6;
    localparam int ADDR_W = 2;
    localparam int DATA_W = LEN_W + ADDR_W;
    localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'd3;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_HDR    = 3'd1;
    localparam state_t S_DATA   = 3'd2;
    localparam state_t S_PARITY = 3'd3;
    localparam state_t S_CHECK  = 3'd4;
    localparam state_t S_DROP   = 3'd5;

    function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] h);
        return h[DATA_W-1:ADDR_W];
    endfunction

    function automatic logic [ADDR_W-1:0] hdr_addr(input logic [DATA_W-1:0] h);
        return h[ADDR_W-1:0];
    endfunction
endpackage

// File: rtl/router_ingress_if.sv
// router_ingress_if: source byte handshake plus the shared write bus to the three router FIFOs.
interface router_ingress_if;
    import router_pkg::*;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [2:0]        fifo_full;
    logic [2:0]        fifo_empty;
    logic [2:0]        fifo_we;
    logic              fifo_lfd;
    logic [DATA_W-1:0] fifo_din;
    modport slave (input in_valid, in_data, fifo_full, fifo_empty,
                   output in_ready, fifo_we, fifo_lfd, fifo_din);
    modport master (output in_valid, in_data, fifo_full, fifo_empty,
                    input in_ready, fifo_we, fifo_lfd, fifo_din);
endinterface

// File: rtl/router_ingress.sv
// router_ingress: steers header/payload/parity bytes into the addressed FIFO, checks parity, drops addr 3.
module router_ingress
    import router_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    router_ingress_if.slave  bus,
    output logic             pkt_done,
    output logic             parity_err,
    output logic             addr_err
);
    state_t            state;
    logic [LEN_W-1:0]  len_cnt;
    logic [DATA_W-1:0] hdr_reg;
    logic [DATA_W-1:0] par_acc;
    logic              par_err_q;
    logic              addr_err_q;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        full4;
    logic [3:0]        empty4;
    logic [2:0]        sel;
    logic              pass;
    logic              hdr_go;
    logic              accept;

    assign addr = hdr_addr(hdr_reg);

    // Flags padded to 4 entries so indexing by a 2-bit address never goes out of range.
    always_comb begin
        full4          = {1'b0, bus.fifo_full};
        empty4         = {1'b0, bus.fifo_empty};
        sel            = 3'b001 << addr;
        pass           = state == S_DATA || state == S_PARITY;
        hdr_go         = state == S_HDR && empty4[addr];
        bus.in_ready   = (state == S_IDLE || state == S_DROP) ? 1'b1 : pass ? !full4[addr] : 1'b0;
        accept         = bus.in_valid && bus.in_ready;
        bus.fifo_we    = (hdr_go || (pass && accept)) ? sel : 3'b000;
        bus.fifo_lfd   = hdr_go;
        bus.fifo_din   = state == S_HDR ? hdr_reg : bus.in_data;
        pkt_done       = state == S_CHECK;
        parity_err     = pkt_done && par_err_q;
        addr_err       = addr_err_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            len_cnt    <= '0;
            hdr_reg    <= '0;
            par_acc    <= '0;
            par_err_q  <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    hdr_reg <= bus.in_data;
                    par_acc <= bus.in_data;
                    len_cnt <= hdr_len(bus.in_data);
                    state   <= hdr_addr(bus.in_data) == INVALID_ADDR ? S_DROP : S_HDR;
                end
                S_HDR: if (hdr_go) state <= len_cnt != '0 ? S_DATA : S_PARITY;
                S_DATA: if (accept) begin
                    par_acc <= par_acc ^ bus.in_data;
                    len_cnt <= len_cnt - 1'b1;
                    if (len_cnt == LEN_W'(1)) state <= S_PARITY;
                end
                S_PARITY: if (accept) begin
                    par_err_q <= bus.in_data != par_acc;
                    state     <= S_CHECK;
                end
                S_CHECK: state <= S_IDLE;
                // len_cnt==0 here means the byte being consumed is the parity byte.
                S_DROP: if (accept) begin
                    if (len_cnt == '0) begin
                        addr_err_q <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        len_cnt <= len_cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_router_ingress.sv
// tb_router_ingress: table-driven cycle vectors plus hand sequences for reset and back-pressure corners.
module tb_router_ingress;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pkt_done, parity_err, addr_err;
    int   total = 0;
    int   bad = 0;
    int   wcnt [3];

    router_ingress_if bus();

    router_ingress dut (
        .clk(clk), .rst(rst), .bus(bus),
        .pkt_done(pkt_done), .parity_err(parity_err), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [2:0] full;
        logic [2:0] empty;
        logic       rdy;
        logic [2:0] we;
        logic       lfd;
        logic [7:0] din;
        logic       done;
        logic       perr;
        logic       aerr;
    } vec_t;

    vec_t tv[$];

    function automatic void add(logic v, logic [7:0] d, logic [2:0] full, logic [2:0] empty,
                                logic rdy, logic [2:0] we, logic lfd, logic [7:0] din,
                                logic done, logic perr, logic aerr);
        vec_t r;
        r.v = v; r.d = d; r.full = full; r.empty = empty;
        r.rdy = rdy; r.we = we; r.lfd = lfd; r.din = din;
        r.done = done; r.perr = perr; r.aerr = aerr;
        tv.push_back(r);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic run(input string name);
        logic [15:0] got, exp;
        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            bus.in_valid   = tv[i].v;
            bus.in_data    = tv[i].d;
            bus.fifo_full  = tv[i].full;
            bus.fifo_empty = tv[i].empty;
            #1;
            got = {bus.in_ready, bus.fifo_we, bus.fifo_lfd, bus.fifo_din, pkt_done, parity_err, addr_err};
            exp = {tv[i].rdy, tv[i].we, tv[i].lfd, tv[i].din, tv[i].done, tv[i].perr, tv[i].aerr};
            chk($sformatf("%s row %0d {rdy,we,lfd,din,done,perr,aerr}", name, i), 32'(got), 32'(exp));
            for (int k = 0; k < 3; k++) if (bus.fifo_we[k]) wcnt[k]++;
        end
        tv.delete();
    endtask

    task automatic clr_cnt();
        for (int k = 0; k < 3; k++) wcnt[k] = 0;
    endtask

    initial begin
        logic [7:0] par;
        logic [7:0] p;
        bus.in_valid = 1'b0; bus.in_data = 8'h00;
        bus.fifo_full = 3'b000; bus.fifo_empty = 3'b111;
        #12;
        chk("reset outputs {rdy,we,lfd,done,perr,aerr}",
            {bus.in_ready, bus.fifo_we, bus.fifo_lfd, pkt_done, parity_err, addr_err}, 32'b1_000_0_000);
        @(negedge clk);
        rst = 1'b1;

        // valid packet then bad-parity packet to FIFO1
        for (int b = 0; b < 2; b++) begin
            clr_cnt();
            add(1, 8'h0D, 0, 7, 1, 3'b000, 0, 8'h0D, 0, 0, 0);
            add(0, 8'h00, 0, 7, 0, 3'b010, 1, 8'h0D, 0, 0, 0);
            add(1, 8'h11, 0, 7, 1, 3'b010, 0, 8'h11, 0, 0, 0);
            add(1, 8'h22, 0, 7, 1, 3'b010, 0, 8'h22, 0, 0, 0);
            add(1, 8'h33, 0, 7, 1, 3'b010, 0, 8'h33, 0, 0, 0);
            par = b == 0 ? 8'h0D : 8'hFF;
            add(1, par,   0, 7, 1, 3'b010, 0, par,   0, 0, 0);
            add(0, 8'h00, 0, 7, 0, 3'b000, 0, 8'h00, 1, b == 1, 0);
            add(0, 8'h00, 0, 7, 1, 3'b000, 0, 8'h00, 0, 0, 0);
            run(b == 0 ? "valid_pkt" : "bad_parity");
            chk("fifo1 writes", wcnt[1], 5);
            chk("fifo0+fifo2 writes", wcnt[0] + wcnt[2], 0);
        end

        // invalid address: dropped, then a len-0 packet accepted right away
        clr_cnt();
        add(1, 8'h3B, 0, 7, 1, 3'b000, 0, 8'h3B, 0, 0, 0);
        for (int i = 0; i < 15; i++) begin
            p = 8'h40 + 8'(i);
            add(1, p, 0, 7, 1, 3'b000, 0, p, 0, 0, 0);
        end
        add(1, 8'h00, 0, 7, 1, 3'b000, 0, 8'h00, 0, 0, 1);
        add(0, 8'h00, 0, 7, 0, 3'b001, 1, 8'h00, 0, 0, 0);
        add(1, 8'h00, 0, 7, 1, 3'b001, 0, 8'h00, 0, 0, 0);
        add(0, 8'h00, 0, 7, 0, 3'b000, 0, 8'h00, 1, 0, 0);
        add(0, 8'h00, 0, 7, 1, 3'b000, 0, 8'h00, 0, 0, 0);
        run("drop_addr3");
        chk("fifo0 writes after drop", wcnt[0], 2);

        // back-pressure on FIFO2 for 4 cycles after the 5th payload
        clr_cnt();
        par = 8'h3A;
        add(1, 8'h3A, 0, 7, 1, 3'b000, 0, 8'h3A, 0, 0, 0);
        add(0, 8'h00, 0, 7, 0, 3'b100, 1, 8'h3A, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            p = 8'h60 + 8'(i);
            par = par ^ p;
            if (i == 5)
                for (int s = 0; s < 4; s++) add(1, p, 3'b100, 7, 0, 3'b000, 0, p, 0, 0, 0);
            add(1, p, 0, 7, 1, 3'b100, 0, p, 0, 0, 0);
        end
        add(1, par,   0, 7, 1, 3'b100, 0, par,   0, 0, 0);
        add(0, 8'h00, 0, 7, 0, 3'b000, 0, 8'h00, 1, 0, 0);
        add(0, 8'h00, 0, 7, 1, 3'b000, 0, 8'h00, 0, 0, 0);
        run("backpressure");
        chk("fifo2 writes", wcnt[2], 16);

        // header held until FIFO0 drains
        add(1, 8'h04, 0, 3'b110, 1, 3'b000, 0, 8'h04, 0, 0, 0);
        for (int s = 0; s < 6; s++) add(0, 8'h00, 0, 3'b110, 0, 3'b000, 0, 8'h04, 0, 0, 0);
        add(0, 8'h00, 0, 7, 0, 3'b001, 1, 8'h04, 0, 0, 0);
        add(1, 8'hAA, 0, 7, 1, 3'b001, 0, 8'hAA, 0, 0, 0);
        add(1, 8'hAE, 0, 7, 1, 3'b001, 0, 8'hAE, 0, 0, 0);
        add(0, 8'h00, 0, 7, 0, 3'b000, 0, 8'h00, 1, 0, 0);
        run("hdr_wait");

        // reset in the middle of DATA
        add(1, 8'h0D, 0, 7, 1, 3'b000, 0, 8'h0D, 0, 0, 0);
        add(0, 8'h00, 0, 7, 0, 3'b010, 1, 8'h0D, 0, 0, 0);
        add(1, 8'h11, 0, 7, 1, 3'b010, 0, 8'h11, 0, 0, 0);
        add(1, 8'h22, 0, 7, 1, 3'b010, 0, 8'h22, 0, 0, 0);
        run("pre_reset");
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 8'h33;
        rst = 1'b0;
        #1;
        chk("mid reset {rdy,we,lfd,done,perr,aerr}",
            {bus.in_ready, bus.fifo_we, bus.fifo_lfd, pkt_done, parity_err, addr_err}, 32'b1_000_0_000);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        add(1, 8'h00, 0, 7, 1, 3'b000, 0, 8'h00, 0, 0, 0);
        add(0, 8'h00, 0, 7, 0, 3'b001, 1, 8'h00, 0, 0, 0);
        add(1, 8'h00, 0, 7, 1, 3'b001, 0, 8'h00, 0, 0, 0);
        add(0, 8'h00, 0, 7, 0, 3'b000, 0, 8'h00, 1, 0, 0);
        add(0, 8'h00, 0, 7, 1, 3'b000, 0, 8'h00, 0, 0, 0);
        run("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
